// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/handshake bundle between the control FSM,
// the multiplier/divisor units and the mult/div sequencer.
// slave  = sequencer view, master = control/unit (environment) view.
interface muldiv_sequencer_if;
   logic       op_valid;
   logic       op_is_div;
   logic       busy;
   logic       done;
   logic       mult_start;
   logic       mult_fim;
   logic       div_start;
   logic       div_fim;
   logic       div_by_zero;
   logic       hi_sel;
   logic       lo_sel;
   logic       hi_write;
   logic       lo_write;
   logic       exc_div0;
   logic       exc_timeout;
   logic [2:0] state;

   modport slave (
      input  op_valid, op_is_div, mult_fim, div_fim, div_by_zero,
      output busy, done, mult_start, div_start, hi_sel, lo_sel,
             hi_write, lo_write, exc_div0, exc_timeout, state
   );

   modport master (
      output op_valid, op_is_div, mult_fim, div_fim, div_by_zero,
      input  busy, done, mult_start, div_start, hi_sel, lo_sel,
             hi_write, lo_write, exc_div0, exc_timeout, state
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one multiply or divide at a time on the shared
// units -- start pulse, wait for completion, then write HI/LO or raise a
// divide-by-zero / timeout exception.
// Build option: MULDIV_TIMEOUT_EN adds the WAIT cycle counter and the
// timeout exception; without it WAIT holds until fim or div0.
module muldiv_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clock,
   input  logic               reset,
   muldiv_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_EXC   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      C_NONE = 2'd0,
      C_DIV0 = 2'd1,
      C_TMO  = 2'd2
   } cause_e;

   state_e state_q, state_d;
   cause_e cause_q, cause_d;
   logic   op_q, op_d;
   logic   sel_fim;
   logic   tmo_hit;

   logic   busy_q, done_q, mstart_q, dstart_q, sel_q, wr_q, exc0_q;

   // only the selected unit's completion flag is observed
   assign sel_fim = op_q ? bus.div_fim : bus.mult_fim;

`ifdef MULDIV_TIMEOUT_EN
   localparam int             CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          exct_q;

   assign tmo_hit = (cnt_q == CNT_MAX);

   // wait counter: cleared in START, counts WAIT cycles, saturates at compare value
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_START)
         cnt_d = '0;
      else if (state_q == S_WAIT && !tmo_hit)
         cnt_d = cnt_q + 1'b1;
   end

   // wait counter register and registered timeout pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         exct_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         exct_q <= (state_d == S_EXC) && (cause_d == C_TMO);
      end
   end

   assign bus.exc_timeout = exct_q;
`else
   assign tmo_hit         = 1'b0;
   assign bus.exc_timeout = 1'b0;
`endif

   // next-state: accept in IDLE, one START cycle, WAIT priority div0 > fim > timeout
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: begin
            if (bus.op_valid) begin
               op_d    = bus.op_is_div;
               state_d = S_START;
            end
         end
         S_START: begin
            cause_d = C_NONE;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (op_q && bus.div_by_zero) begin
               cause_d = C_DIV0;
               state_d = S_EXC;
            end else if (sel_fim) begin
               state_d = S_WRITE;
            end else if (tmo_hit) begin
               cause_d = C_TMO;
               state_d = S_EXC;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_EXC:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state, latched op, cause, and outputs registered from the next state
   // so every output is a clean flop that matches the state it labels
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         cause_q  <= C_NONE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mstart_q <= 1'b0;
         dstart_q <= 1'b0;
         sel_q    <= 1'b0;
         wr_q     <= 1'b0;
         exc0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cause_q  <= cause_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_WRITE) || (state_d == S_EXC);
         mstart_q <= (state_d == S_START) && !op_d;
         dstart_q <= (state_d == S_START) && op_d;
         sel_q    <= op_d;
         wr_q     <= (state_d == S_WRITE);
         exc0_q   <= (state_d == S_EXC) && (cause_d == C_DIV0);
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.mult_start = mstart_q;
   assign bus.div_start  = dstart_q;
   assign bus.hi_sel     = sel_q;
   assign bus.lo_sel     = sel_q;
   assign bus.hi_write   = wr_q;
   assign bus.lo_write   = wr_q;
   assign bus.exc_div0   = exc0_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: transaction-level reference check of muldiv_sequencer.
// Each operation's end cycle and outcome are planned up front from the
// request's fim/div0 timing, then every cycle's outputs are compared.
module tb_muldiv_sequencer;

   localparam int TMO  = 8;
   localparam int NONE = 100000;
`ifdef MULDIV_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   muldiv_sequencer_if bus ();

   muldiv_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [12:0] obs_v;
   assign obs_v = {bus.busy, bus.done, bus.mult_start, bus.div_start,
                   bus.hi_sel, bus.lo_sel, bus.hi_write, bus.lo_write,
                   bus.exc_div0, bus.exc_timeout, bus.state};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // expected output vector in cycle c of an op ending (done) in cycle T
   // kind: 0 write, 1 div0, 2 timeout
   function automatic logic [12:0] exp_vec(int c, int T, bit op, int kind);
      logic busy, done, ms, ds, wr, ed, et;
      logic [2:0] st;
      busy = 0; done = 0; ms = 0; ds = 0; wr = 0; ed = 0; et = 0; st = 3'd0;
      if (c == 1) begin
         busy = 1; ms = !op; ds = op; st = 3'd1;
      end else if (c < T) begin
         busy = 1; st = 3'd2;
      end else if (c == T) begin
         busy = 1; done = 1;
         if (kind == 0) begin
            wr = 1; st = 3'd3;
         end else begin
            st = 3'd4; ed = (kind == 1); et = (kind == 2);
         end
      end
      return {busy, done, ms, ds, op, op, wr, wr, ed, et, st};
   endfunction

   // first WAIT cycle (from cycle 2) that satisfies a rule decides the outcome
   task automatic plan(input bit d, input int f, input int z, output int T, output int kind);
      int w;
      w = 2; kind = -1;
      while (kind < 0) begin
         if (d && z <= w)                 kind = 1;
         else if (f <= w)                 kind = 0;
         else if (TO_EN && w == TMO + 1)  kind = 2;
         else                             w++;
      end
      T = w + 1;
   endtask

   // issue from an IDLE cycle; unit flags rise in cycle f (fim) / z (div0)
   task automatic run_op(input bit d, input int f, input int z, input bit noise);
      int T, kind;
      plan(d, f, z, T, kind);
      bus.op_valid  = 1'b1;
      bus.op_is_div = d;
      for (int c = 1; c <= T + 1; c++) begin
         @(posedge clk); #1;
         if (c <= T) begin
            bus.op_valid    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.op_is_div   = noise ? 1'($urandom_range(0, 1)) : d;
            bus.mult_fim    = !d ? (c >= f) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.div_fim     = d  ? (c >= f) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.div_by_zero = d  ? (c >= z) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
         end else begin
            bus.op_valid = 0; bus.op_is_div = 0;
            bus.mult_fim = 0; bus.div_fim = 0; bus.div_by_zero = 0;
         end
         @(negedge clk);
         chk(d ? "div_cyc" : "mul_cyc", 32'(obs_v), 32'(exp_vec(c, T, d, kind)));
      end
   endtask

   initial begin
      bus.op_valid = 0; bus.op_is_div = 0;
      bus.mult_fim = 0; bus.div_fim = 0; bus.div_by_zero = 0;
      #12;
      chk("reset_outs", 32'(obs_v), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 32'(obs_v), 32'd0);

      // multiply, fim in cycle 34
      run_op(1'b0, 34, NONE, 1'b0);
      // divide by zero with fim in the same cycle
      run_op(1'b1, 5, 5, 1'b0);
      // divide with no completion for 200 cycles (timeout if compiled in)
      run_op(1'b1, 201, NONE, 1'b0);
      // multiply with divisor-side noise and stray requests
      run_op(1'b0, 12, NONE, 1'b1);

      // reset mid-WAIT
      bus.op_valid = 1'b1; bus.op_is_div = 1'b1;
      @(posedge clk); #1; bus.op_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_state", 32'(bus.state), 32'd2);
      #1; rst_n = 1'b0;
      #1;
      chk("rst_async", 32'(obs_v), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold", 32'(obs_v), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release", 32'(obs_v), 32'd0);
      run_op(1'b1, 6, NONE, 1'b0);

      // randomized operations, back to back
      for (int i = 0; i < 40; i++) begin
         bit d;
         int f, z;
         d = 1'($urandom_range(0, 1));
         f = $urandom_range(1, 20);
         z = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : NONE;
         run_op(d, f, z, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
